event_counter_bank: RTL and testbench
=====================================

// Module: event_counter_bank
// PURPOSE
//   Parametrised bank of NUM_CH independent event counters, each CNT_W bits wide,
//   with per-channel wrap or saturate mode and sticky overflow flags.
//   An atomic snapshot of all channels is taken on request and held on a
//   valid/ready output until consumed; counting continues meanwhile.
//   Sits beside datapath blocks as a performance/statistics counter source.
// PARAMETERS
//   NUM_CH       2      number of counter channels (>=1)
//   CNT_W        16     counter width in bits (>=2)
//   SAT_MASK     '0     NUM_CH-bit mask; bit c=1: channel c saturates, 0: wraps
//   CLR_ON_SNAP  0      1: counters are cleared when a snapshot is captured
// PORTS
//   clk          in   1              clock, all logic on rising edge
//   rst_n        in   1              synchronous active-low reset
//   inc_i        in   NUM_CH         per-channel increment strobe (+1 per cycle)
//   clr_i        in   1              clear all counters and overflow flags
//   snap_req_i   in   1              snapshot request (single-cycle or level)
//   snap_busy_o  out  1              snapshot held, new requests ignored
//   snap_valid_o out  1              snapshot data valid
//   snap_ready_i in   1              consumer accepts snapshot
//   snap_data_o  out  NUM_CH*CNT_W   packed array count_t [NUM_CH-1:0], ch0 in LSBs
//   snap_ovf_o   out  NUM_CH         overflow flags captured with the snapshot
//   ovf_o        out  NUM_CH         live sticky overflow flags
// BEHAVIOUR
//   - Reset (rst_n=0 at clk edge): counters=0, ovf_o=0, snap_data_o=0, snap_ovf_o=0,
//     snap_valid_o=0, snap_busy_o=0, FSM=IDLE. Reset mid-HOLD drops the snapshot.
//   - Counter update priority per channel: clr_i > snapshot-clear > inc_i.
//   - Wrap channel: all-ones + inc -> 0, ovf sticky set same edge.
//   - Saturate channel: at all-ones, inc holds all-ones and sets ovf; no wrap.
//   - ovf flags clear only on reset, clr_i, or snapshot capture when CLR_ON_SNAP=1.
//   - FSM IDLE: snap_req_i=1 -> capture at that edge, go HOLD. Captured value is the
//     pre-increment counter value of that cycle (increment in the capture cycle is
//     not in the snapshot). CLR_ON_SNAP=1: counter loads (inc_i[c]?1:0), ovf loads 0
//     (no increment is lost across the snapshot boundary).
//   - FSM HOLD: snap_valid_o=1, snap_busy_o=1, snap_data_o/snap_ovf_o stable.
//     snap_ready_i=1 -> IDLE next edge. snap_req_i ignored (not queued) in HOLD.
//   - Latency: request edge -> snap_valid_o high 1 cycle later (registered output).
//     Minimum request-to-request period 2 cycles (ready held high).
//   - clr_i during HOLD clears live counters only; held snapshot unaffected.
//   - clr_i together with capture in IDLE: snapshot gets pre-clear values.
//   - Widths: snap_data_o exactly NUM_CH*CNT_W bits; no implicit extension.
// STRUCTURE
//   - Package event_counter_pkg: typedef enum logic {IDLE, HOLD} snap_state_e;
//     localparam DEFAULT_CNT_W = 16, DEFAULT_NUM_CH = 2.
//   - count_t typedef local to the module: logic [CNT_W-1:0]; data as count_t [NUM_CH-1:0].
//   - Sub-module event_counter_chan (one counter + sticky ovf, params CNT_W, SATURATE,
//     CLR_ON_SNAP), instantiated NUM_CH times in a generate loop; snapshot FSM in top.
// TESTING
//   1 Reset: hold rst_n=0 2 cycles with inc_i=all-ones -> all outputs 0 after release.
//   2 Wrap: CNT_W=4, ch0 wrap, 16 incs -> counter 0, ovf_o[0]=1; 3 more -> 3, ovf still 1.
//   3 Saturate: SAT_MASK=2'b10, ch1 20 incs (CNT_W=4) -> stays 15, ovf_o[1]=1.
//   4 Snapshot: ch0=5, ch1=9, req with inc_i=2'b11 -> snap_data_o={9,5} next cycle,
//     live counters {10,6}; ready low 3 cycles -> data stable, busy=1; ready -> IDLE.
//   5 CLR_ON_SNAP=1: ch0=7, req with inc_i[0]=1 -> snapshot 7, live counter 1, ovf 0.
//   6 Reset in HOLD: rst_n=0 while snap_valid_o=1 -> valid, busy, data 0 next edge.

Source files
------------

// File: rtl/event_counter_pkg.sv
// Shared types and defaults for the event counter bank.
package event_counter_pkg;
    typedef enum logic {IDLE, HOLD} snap_state_e;

    localparam int unsigned DEFAULT_CNT_W  = 16;
    localparam int unsigned DEFAULT_NUM_CH = 2;
endpackage

// File: rtl/event_counter_chan.sv
// Single event counter with sticky overflow flag; wraps or saturates at all-ones.
module event_counter_chan
    import event_counter_pkg::*;
#(
    parameter int unsigned CNT_W       = DEFAULT_CNT_W,
    parameter bit          SATURATE    = 1'b0,
    parameter bit          CLR_ON_SNAP = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    input  logic             snap,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (clr) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (CLR_ON_SNAP && snap) begin
            // The capture-cycle increment restarts the count so no event is lost.
            count <= {{(CNT_W-1){1'b0}}, inc};
            ovf   <= 1'b0;
        end else if (inc) begin
            if (count == '1) begin
                ovf <= 1'b1;
                if (!SATURATE) begin
                    count <= '0;
                end
            end else begin
                count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/event_counter_bank.sv
// Bank of independent event counters with an atomic snapshot held on a
// valid/ready output while live counting continues.
module event_counter_bank
    import event_counter_pkg::*;
#(
    parameter int unsigned       NUM_CH      = DEFAULT_NUM_CH,
    parameter int unsigned       CNT_W       = DEFAULT_CNT_W,
    parameter logic [NUM_CH-1:0] SAT_MASK    = '0,
    parameter bit                CLR_ON_SNAP = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       inc_i,
    input  logic                    clr_i,
    input  logic                    snap_req_i,
    output logic                    snap_busy_o,
    output logic                    snap_valid_o,
    input  logic                    snap_ready_i,
    output logic [NUM_CH*CNT_W-1:0] snap_data_o,
    output logic [NUM_CH-1:0]       snap_ovf_o,
    output logic [NUM_CH-1:0]       ovf_o
);

    typedef logic [CNT_W-1:0] count_t;

    count_t [NUM_CH-1:0] live_cnt;
    count_t [NUM_CH-1:0] snap_data_q;
    logic   [NUM_CH-1:0] live_ovf;
    logic   [NUM_CH-1:0] snap_ovf_q;
    snap_state_e         state;
    snap_state_e         state_nxt;
    logic                capture;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        event_counter_chan #(
            .CNT_W      (CNT_W),
            .SATURATE   (SAT_MASK[c]),
            .CLR_ON_SNAP(CLR_ON_SNAP)
        ) u_chan (
            .clk  (clk),
            .rst_n(rst_n),
            .inc  (inc_i[c]),
            .clr  (clr_i),
            .snap (capture),
            .count(live_cnt[c]),
            .ovf  (live_ovf[c])
        );
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (snap_req_i) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (snap_ready_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Captured from the pre-update register values, so clr_i or the capture
    // increment in the same cycle never leak into the snapshot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            snap_data_q <= '0;
            snap_ovf_q  <= '0;
        end else if (capture) begin
            snap_data_q <= live_cnt;
            snap_ovf_q  <= live_ovf;
        end
    end

    assign snap_data_o  = snap_data_q;
    assign snap_ovf_o   = snap_ovf_q;
    assign snap_valid_o = (state == HOLD);
    assign snap_busy_o  = (state == HOLD);
    assign ovf_o        = live_ovf;

endmodule

// File: tb/tb_event_counter_bank.sv
// Bench for event_counter_bank: a wrap/saturate instance checked through a
// snapshot scoreboard, plus a clear-on-snapshot instance checked directly.
module tb_event_counter_bank;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] ovf;
    } snap_exp_t;

    logic       clk;
    logic       rst_n;

    logic [1:0] inc_a, ovf_a, snap_ovf_a;
    logic       clr_a, req_a, rdy_a, busy_a, valid_a;
    logic [7:0] data_a;

    logic [1:0] inc_b, ovf_b, snap_ovf_b;
    logic       clr_b, req_b, rdy_b, busy_b, valid_b;
    logic [7:0] data_b;

    int unsigned n_checks;
    int unsigned n_fail;

    snap_exp_t   exp_q[$];
    snap_exp_t   got;
    int unsigned m_cnt[2];
    logic [1:0]  m_ovf;
    bit          m_hold;
    logic [1:0]  m_sat;

    event_counter_bank #(
        .NUM_CH     (2),
        .CNT_W      (4),
        .SAT_MASK   (2'b10),
        .CLR_ON_SNAP(1'b0)
    ) dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .inc_i       (inc_a),
        .clr_i       (clr_a),
        .snap_req_i  (req_a),
        .snap_busy_o (busy_a),
        .snap_valid_o(valid_a),
        .snap_ready_i(rdy_a),
        .snap_data_o (data_a),
        .snap_ovf_o  (snap_ovf_a),
        .ovf_o       (ovf_a)
    );

    event_counter_bank #(
        .NUM_CH     (2),
        .CNT_W      (4),
        .SAT_MASK   (2'b00),
        .CLR_ON_SNAP(1'b1)
    ) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .inc_i       (inc_b),
        .clr_i       (clr_b),
        .snap_req_i  (req_b),
        .snap_busy_o (busy_b),
        .snap_valid_o(valid_b),
        .snap_ready_i(rdy_b),
        .snap_data_o (data_b),
        .snap_ovf_o  (snap_ovf_b),
        .ovf_o       (ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard pop on every accepted snapshot of dut_a.
    always @(negedge clk) begin
        if (rst_n && valid_a && rdy_a) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got data=%h ovf=%b, queue empty", data_a, snap_ovf_a);
            end else begin
                got = exp_q.pop_front();
                if (data_a !== got.data || snap_ovf_a !== got.ovf) begin
                    n_fail++;
                    $display("FAIL sb_snapshot: got data=%h ovf=%b, expected data=%h ovf=%b",
                             data_a, snap_ovf_a, got.data, got.ovf);
                end
            end
        end
    end

    task automatic model_reset();
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        m_ovf    = 2'b00;
        m_hold   = 1'b0;
        exp_q.delete();
    endtask

    // One clock of dut_a; the model advances from the values seen before the edge.
    task automatic step_a(input logic [1:0] inc, input logic clr, input logic req, input logic rdy);
        inc_a = inc;
        clr_a = clr;
        req_a = req;
        rdy_a = rdy;
        if (!m_hold && req) begin
            exp_q.push_back('{data: {m_cnt[1][3:0], m_cnt[0][3:0]}, ovf: m_ovf});
            m_hold = 1'b1;
        end else if (m_hold && rdy) begin
            m_hold = 1'b0;
        end
        for (int c = 0; c < 2; c++) begin
            if (clr) begin
                m_cnt[c] = 0;
                m_ovf[c] = 1'b0;
            end else if (inc[c]) begin
                if (m_cnt[c] == 15) begin
                    m_ovf[c] = 1'b1;
                    m_cnt[c] = m_sat[c] ? 15 : 0;
                end else begin
                    m_cnt[c] = m_cnt[c] + 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic read_a();
        step_a(2'b00, 1'b0, 1'b1, 1'b0);
        step_a(2'b00, 1'b0, 1'b0, 1'b1);
        step_a(2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step_b(input logic [1:0] inc, input logic req, input logic rdy);
        inc_b = inc;
        req_b = req;
        rdy_b = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        inc_a = 2'b11; clr_a = 1'b0; req_a = 1'b0; rdy_a = 1'b0;
        inc_b = 2'b11; clr_b = 1'b0; req_b = 1'b0; rdy_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        inc_a = 2'b00;
        inc_b = 2'b00;
        model_reset();
        n_checks++;
        if (ovf_a !== 2'b00) begin n_fail++; $display("FAIL reset_ovf: got %b, expected 00", ovf_a); end
        n_checks++;
        if (data_a !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h, expected 00", data_a); end
        n_checks++;
        if (snap_ovf_a !== 2'b00) begin n_fail++; $display("FAIL reset_snap_ovf: got %b, expected 00", snap_ovf_a); end
        n_checks++;
        if (valid_a !== 1'b0 || busy_a !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid_busy: got %b%b, expected 00", valid_a, busy_a);
        end
        n_checks++;
        if (valid_b !== 1'b0 || data_b !== 8'h00 || ovf_b !== 2'b00) begin
            n_fail++; $display("FAIL reset_b: got valid=%b data=%h ovf=%b, expected 0/00/00", valid_b, data_b, ovf_b);
        end
        read_a();
    endtask

    task automatic test_wrap();
        repeat (15) step_a(2'b01, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (ovf_a !== 2'b00) begin n_fail++; $display("FAIL wrap_ovf_at_15: got %b, expected 00", ovf_a); end
        step_a(2'b01, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (ovf_a !== 2'b01) begin n_fail++; $display("FAIL wrap_ovf_set: got %b, expected 01", ovf_a); end
        step_a(2'b00, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (data_a !== 8'h00 || snap_ovf_a !== 2'b01) begin
            n_fail++; $display("FAIL wrap_count0: got data=%h ovf=%b, expected 00/01", data_a, snap_ovf_a);
        end
        step_a(2'b00, 1'b0, 1'b0, 1'b1);
        repeat (3) step_a(2'b01, 1'b0, 1'b0, 1'b0);
        step_a(2'b00, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (data_a !== 8'h03 || ovf_a !== 2'b01) begin
            n_fail++; $display("FAIL wrap_count3: got data=%h ovf=%b, expected 03/01", data_a, ovf_a);
        end
        step_a(2'b00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_saturate();
        step_a(2'b00, 1'b1, 1'b0, 1'b0);
        repeat (20) step_a(2'b10, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (ovf_a !== 2'b10) begin n_fail++; $display("FAIL sat_ovf: got %b, expected 10", ovf_a); end
        step_a(2'b00, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (data_a !== 8'hF0) begin n_fail++; $display("FAIL sat_hold15: got %h, expected f0", data_a); end
        step_a(2'b00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_snapshot();
        step_a(2'b00, 1'b1, 1'b0, 1'b0);
        repeat (5) step_a(2'b11, 1'b0, 1'b0, 1'b0);
        repeat (4) step_a(2'b10, 1'b0, 1'b0, 1'b0);
        step_a(2'b11, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (valid_a !== 1'b1 || data_a !== 8'h95) begin
            n_fail++; $display("FAIL snap_capture: got valid=%b data=%h, expected 1/95", valid_a, data_a);
        end
        for (int i = 0; i < 3; i++) begin
            // A request while held must be ignored, not queued.
            step_a(2'b00, 1'b0, (i == 1), 1'b0);
            n_checks++;
            if (data_a !== 8'h95 || busy_a !== 1'b1 || valid_a !== 1'b1) begin
                n_fail++; $display("FAIL snap_hold: got data=%h busy=%b valid=%b, expected 95/1/1", data_a, busy_a, valid_a);
            end
        end
        step_a(2'b00, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (valid_a !== 1'b0 || busy_a !== 1'b0) begin
            n_fail++; $display("FAIL snap_release: got valid=%b busy=%b, expected 0/0", valid_a, busy_a);
        end
        step_a(2'b00, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (data_a !== 8'hA6) begin n_fail++; $display("FAIL snap_live: got %h, expected a6", data_a); end
        // Clear during hold affects live counters only.
        step_a(2'b00, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (data_a !== 8'hA6) begin n_fail++; $display("FAIL snap_clr_in_hold: got %h, expected a6", data_a); end
        step_a(2'b00, 1'b0, 1'b0, 1'b1);
        step_a(2'b01, 1'b0, 1'b0, 1'b0);
        // Clear with capture: snapshot sees the pre-clear value.
        step_a(2'b00, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (data_a !== 8'h01) begin n_fail++; $display("FAIL snap_clr_with_cap: got %h, expected 01", data_a); end
        step_a(2'b00, 1'b0, 1'b0, 1'b1);
        read_a();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            step_a(2'(i + 1), 1'b0, 1'b1, 1'b1);
            n_checks++;
            if (valid_a !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b, expected 1", i, valid_a); end
            step_a(2'b11, 1'b0, 1'b1, 1'b1);
            n_checks++;
            if (valid_a !== 1'b0) begin n_fail++; $display("FAIL b2b_idle[%0d]: got %b, expected 0", i, valid_a); end
        end
        step_a(2'b00, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_drain: got %0d pending, expected 0", exp_q.size()); end
    endtask

    task automatic test_clr_on_snap();
        repeat (23) step_b(2'b01, 1'b0, 1'b0);
        n_checks++;
        if (ovf_b !== 2'b01) begin n_fail++; $display("FAIL cos_ovf_pre: got %b, expected 01", ovf_b); end
        step_b(2'b01, 1'b1, 1'b0);
        n_checks++;
        if (data_b !== 8'h07 || snap_ovf_b !== 2'b01) begin
            n_fail++; $display("FAIL cos_snapshot: got data=%h ovf=%b, expected 07/01", data_b, snap_ovf_b);
        end
        n_checks++;
        if (ovf_b !== 2'b00) begin n_fail++; $display("FAIL cos_ovf_clr: got %b, expected 00", ovf_b); end
        step_b(2'b00, 1'b0, 1'b1);
        step_b(2'b00, 1'b1, 1'b0);
        n_checks++;
        if (data_b !== 8'h01 || snap_ovf_b !== 2'b00) begin
            n_fail++; $display("FAIL cos_live1: got data=%h ovf=%b, expected 01/00", data_b, snap_ovf_b);
        end
        step_b(2'b00, 1'b0, 1'b1);
    endtask

    task automatic test_reset_in_hold();
        repeat (3) step_a(2'b11, 1'b0, 1'b0, 1'b0);
        step_a(2'b00, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (valid_a !== 1'b1 || data_a === 8'h00) begin
            n_fail++; $display("FAIL rih_pre: got valid=%b data=%h, expected 1/nonzero", valid_a, data_a);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        n_checks++;
        if (valid_a !== 1'b0 || busy_a !== 1'b0 || data_a !== 8'h00 || snap_ovf_a !== 2'b00) begin
            n_fail++; $display("FAIL rih_drop: got valid=%b busy=%b data=%h ovf=%b, expected 0/0/00/00",
                               valid_a, busy_a, data_a, snap_ovf_a);
        end
        read_a();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_sat    = 2'b10;
        model_reset();
        test_reset();
        test_wrap();
        test_saturate();
        test_snapshot();
        test_back_to_back();
        test_clr_on_snap();
        test_reset_in_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
